// File: rtl/beta_pipe_ctrl_if.sv
// Beta pipeline control bus: fetch-side inputs and the
// per-stage decode/writeback controls returned by the controller.
interface beta_pipe_ctrl_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        branch_taken;
    logic        stall;
    logic        stall_cnt_clr;
    logic        fetch_adv;
    logic [14:0] ir_decode;
    logic [14:0] ir_exec;
    logic [14:0] ir_mem;
    logic [14:0] ir_wb;
    logic        opcode_type_op;
    logic        op_ld_or_ldr_exec;
    logic        op_ld_or_ldr_mem;
    logic        op_ld_or_ldr_wb;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        we;
    logic [4:0]  wa;
    logic [15:0] stall_cnt;

    modport master (
        output instr_valid, instr, branch_taken, stall, stall_cnt_clr,
        input  fetch_adv, ir_decode, ir_exec, ir_mem, ir_wb,
        input  opcode_type_op, op_ld_or_ldr_exec, op_ld_or_ldr_mem,
        input  op_ld_or_ldr_wb, ra1, ra2, we, wa, stall_cnt
    );

    modport slave (
        input  instr_valid, instr, branch_taken, stall, stall_cnt_clr,
        output fetch_adv, ir_decode, ir_exec, ir_mem, ir_wb,
        output opcode_type_op, op_ld_or_ldr_exec, op_ld_or_ldr_mem,
        output op_ld_or_ldr_wb, ra1, ra2, we, wa, stall_cnt
    );
endinterface

// File: rtl/beta_pipe_ctrl.sv
// Beta 5-stage pipeline controller: tracks decode/exec/mem/wb
// instruction state, handles stall/annul and derives RF controls.
module beta_pipe_ctrl (
    input  logic            clk,
    input  logic            rst_n,
    beta_pipe_ctrl_if.slave bus
);

    typedef struct packed {
        logic        v;
        logic [5:0]  op;
        logic [14:0] f;
    } stage_t;

    localparam stage_t BUBBLE = '{v: 1'b0, op: 6'h00, f: 15'h7FFF};

    stage_t dec_q, ex_q, mem_q, wb_q;
    stage_t fetched;
    logic   annul;
    logic [15:0] cnt_q;
    logic   unused_instr;

    function automatic logic is_ld(input stage_t s);
        return s.v && (s.op == 6'h18 || s.op == 6'h1F);
    endfunction

    function automatic logic writes_rf(input logic [5:0] op);
        logic r;
        r = 1'b0;
        unique case (1'b1)
            op[5]:        r = 1'b1;
            op == 6'h18:  r = 1'b1;
            op == 6'h1B:  r = 1'b1;
            op == 6'h1C:  r = 1'b1;
            op == 6'h1D:  r = 1'b1;
            op == 6'h1F:  r = 1'b1;
            default:      r = 1'b0;
        endcase
        return r;
    endfunction

    assign unused_instr = ^bus.instr[10:0];

    assign fetched = '{v: 1'b1, op: bus.instr[31:26], f: bus.instr[25:11]};
    assign annul   = bus.branch_taken && dec_q.v;

    // Stage advance: stall holds decode and injects an exec bubble,
    // a taken branch annuls the instruction being fetched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q <= BUBBLE;
            ex_q  <= BUBBLE;
            mem_q <= BUBBLE;
            wb_q  <= BUBBLE;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (bus.stall) begin
                ex_q <= BUBBLE;
            end else begin
                ex_q <= dec_q;
                if (annul || !bus.instr_valid) begin
                    dec_q <= BUBBLE;
                end else begin
                    dec_q <= fetched;
                end
            end
        end
    end

    // Saturating stall counter, clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'h0000;
        end else if (bus.stall_cnt_clr) begin
            cnt_q <= 16'h0000;
        end else if (bus.stall && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'h0001;
        end
    end

    assign bus.stall_cnt = cnt_q;
    assign bus.fetch_adv = !bus.stall;

    assign bus.ir_decode = dec_q.f;
    assign bus.ir_exec   = ex_q.f;
    assign bus.ir_mem    = mem_q.f;
    assign bus.ir_wb     = wb_q.f;

    assign bus.opcode_type_op = dec_q.v && (dec_q.op[5:4] == 2'b10);

    assign bus.op_ld_or_ldr_exec = is_ld(ex_q);
    assign bus.op_ld_or_ldr_mem  = is_ld(mem_q);
    assign bus.op_ld_or_ldr_wb   = is_ld(wb_q);

    assign bus.ra1 = dec_q.f[9:5];
    assign bus.ra2 = (dec_q.op[5:4] == 2'b10) ? dec_q.f[4:0]
                                              : dec_q.f[14:10];

    assign bus.wa = wb_q.f[14:10];
    assign bus.we = wb_q.v && (wb_q.f[14:10] != 5'd31)
                    && writes_rf(wb_q.op);

endmodule

// File: tb/tb_beta_pipe_ctrl.sv
// Randomized and directed bench for beta_pipe_ctrl against a
// queue-based model of the four instruction slots.
module tb_beta_pipe_ctrl;

    typedef struct {
        bit          v;
        logic [31:0] w;
    } slot_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    int   cnt_m;
    slot_t pipe[$];

    beta_pipe_ctrl_if bus();

    beta_pipe_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int rc,
                                       input int ra, input int rb);
        logic [31:0] w;
        w = {op[5:0], rc[4:0], ra[4:0], rb[4:0], 11'h0};
        return w;
    endfunction

    function automatic int opc(input slot_t s);
        return s.v ? int'(s.w[31:26]) : 0;
    endfunction

    function automatic int rc_of(input slot_t s);
        return s.v ? int'(s.w[25:21]) : 31;
    endfunction

    function automatic int ra_of(input slot_t s);
        return s.v ? int'(s.w[20:16]) : 31;
    endfunction

    function automatic int rb_of(input slot_t s);
        return s.v ? int'(s.w[15:11]) : 31;
    endfunction

    function automatic logic [31:0] ir_of(input slot_t s);
        return 32'(rc_of(s) * 1024 + ra_of(s) * 32 + rb_of(s));
    endfunction

    function automatic bit ld_of(input slot_t s);
        return s.v && (opc(s) == 'h18 || opc(s) == 'h1F);
    endfunction

    function automatic bit we_of(input slot_t s);
        int o;
        bit ok;
        o = opc(s);
        ok = (o >= 'h20 && o <= 'h3F) || o == 'h18 || o == 'h1B
             || o == 'h1C || o == 'h1D || o == 'h1F;
        return s.v && ok && rc_of(s) != 31;
    endfunction

    function automatic slot_t bub();
        slot_t s;
        s.v = 1'b0;
        s.w = 32'h0;
        return s;
    endfunction

    task automatic model_reset();
        pipe.delete();
        for (int i = 0; i < 4; i++) pipe.push_back(bub());
        cnt_m = 0;
    endtask

    task automatic model_edge();
        slot_t s;
        if (bus.stall) begin
            pipe.insert(1, bub());
        end else begin
            s.v = 1'b1;
            s.w = bus.instr;
            if (!bus.instr_valid || (bus.branch_taken && pipe[0].v))
                s = bub();
            pipe.push_front(s);
        end
        void'(pipe.pop_back());
        if (bus.stall_cnt_clr) cnt_m = 0;
        else if (bus.stall && cnt_m < 65535) cnt_m++;
    endtask

    task automatic check_all();
        int o;
        o = opc(pipe[0]);
        chk("ir_decode", 32'(bus.ir_decode), ir_of(pipe[0]));
        chk("ir_exec", 32'(bus.ir_exec), ir_of(pipe[1]));
        chk("ir_mem", 32'(bus.ir_mem), ir_of(pipe[2]));
        chk("ir_wb", 32'(bus.ir_wb), ir_of(pipe[3]));
        chk("fetch_adv", 32'(bus.fetch_adv), 32'(!bus.stall));
        chk("type_op", 32'(bus.opcode_type_op),
            32'(pipe[0].v && o >= 'h20 && o <= 'h2F));
        chk("ld_exec", 32'(bus.op_ld_or_ldr_exec), 32'(ld_of(pipe[1])));
        chk("ld_mem", 32'(bus.op_ld_or_ldr_mem), 32'(ld_of(pipe[2])));
        chk("ld_wb", 32'(bus.op_ld_or_ldr_wb), 32'(ld_of(pipe[3])));
        chk("ra1", 32'(bus.ra1), 32'(ra_of(pipe[0])));
        chk("ra2", 32'(bus.ra2), 32'((o >= 'h20 && o <= 'h2F)
                                     ? rb_of(pipe[0]) : rc_of(pipe[0])));
        chk("we", 32'(bus.we), 32'(we_of(pipe[3])));
        chk("wa", 32'(bus.wa), 32'(rc_of(pipe[3])));
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(cnt_m));
    endtask

    task automatic step(input bit iv, input logic [31:0] w, input bit br,
                        input bit st, input bit clr, input bit full);
        bus.instr_valid   = iv;
        bus.instr         = w;
        bus.branch_taken  = br;
        bus.stall         = st;
        bus.stall_cnt_clr = clr;
        #1;
        if (full) check_all();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_instr();
        int pick;
        int op;
        pick = int'($urandom_range(0, 9));
        case (pick)
            0: op = 'h18;
            1: op = 'h19;
            2: op = 'h1B;
            3: op = 'h1F;
            4: op = int'($urandom_range('h20, 'h2F));
            5: op = int'($urandom_range('h30, 'h3F));
            6: op = int'($urandom_range('h1C, 'h1D));
            default: op = int'($urandom_range(0, 63));
        endcase
        return mk(op, int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    endfunction

    localparam int ADD = 'h20;
    localparam int LD  = 'h18;
    localparam int ST  = 'h19;
    localparam int JMP = 'h1B;

    initial begin
        logic [31:0] a;
        n_chk = 0;
        n_err = 0;
        model_reset();
        rst_n = 1'b0;
        bus.instr_valid   = 1'b0;
        bus.instr         = 32'h0;
        bus.branch_taken  = 1'b0;
        bus.stall         = 1'b0;
        bus.stall_cnt_clr = 1'b0;
        @(negedge clk);
        step(1, mk(ADD, 1, 2, 3), 1, 1, 0, 1);
        chk("rst_ir_wb", 32'(bus.ir_wb), 32'h7FFF);
        chk("rst_wa", 32'(bus.wa), 32'd31);
        rst_n = 1'b1;

        step(1, mk(ADD, 3, 1, 2), 0, 0, 0, 1);
        step(0, 32'h0, 0, 0, 0, 1);
        chk("add_exec", 32'(bus.ir_exec), 32'h0C22);
        step(0, 32'h0, 0, 0, 0, 1);
        step(0, 32'h0, 0, 0, 0, 1);
        chk("add_we", 32'(bus.we), 32'd1);
        chk("add_wa", 32'(bus.wa), 32'd3);

        step(1, mk(LD, 4, 1, 0), 0, 0, 1, 1);
        step(1, mk(ADD, 6, 4, 4), 0, 0, 0, 1);
        chk("lu_ld_exec", 32'(bus.op_ld_or_ldr_exec), 32'd1);
        step(1, mk(ADD, 9, 9, 9), 0, 1, 0, 1);
        step(1, mk(ADD, 9, 9, 9), 0, 1, 0, 1);
        chk("lu_dec_hold", 32'(bus.ir_decode), 32'h1884);
        chk("lu_exec_bub", 32'(bus.ir_exec), 32'h7FFF);
        chk("lu_cnt", 32'(bus.stall_cnt), 32'd2);
        step(0, 32'h0, 0, 0, 0, 1);
        chk("lu_adv", 32'(bus.ir_exec), 32'h1884);

        step(1, mk(JMP, 5, 2, 0), 0, 0, 0, 1);
        step(1, mk(ADD, 8, 8, 8), 1, 0, 0, 1);
        chk("annul_dec", 32'(bus.ir_decode), 32'h7FFF);
        step(0, 32'h0, 0, 0, 0, 1);
        step(0, 32'h0, 0, 0, 0, 1);
        chk("jmp_we", 32'(bus.we), 32'd1);
        chk("jmp_wa", 32'(bus.wa), 32'd5);

        a = mk(ADD, 10, 11, 12);
        step(1, a, 0, 0, 0, 1);
        step(1, mk(ADD, 13, 13, 13), 1, 1, 0, 1);
        chk("conf_hold", 32'(bus.ir_decode), 32'(a[25:11]));
        step(0, 32'h0, 0, 0, 0, 1);

        step(1, mk(ST, 7, 1, 0), 0, 0, 0, 1);
        step(1, mk(ADD, 31, 1, 2), 0, 0, 0, 1);
        step(0, 32'h0, 0, 0, 0, 1);
        step(0, 32'h0, 0, 0, 0, 1);
        chk("st_we", 32'(bus.we), 32'd0);
        step(0, 32'h0, 0, 0, 0, 1);
        chk("r31_we", 32'(bus.we), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), rnd_instr(),
                 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 40) == 0), 1);
            if (i == 1500) begin
                step(1, rnd_instr(), 0, 1, 0, 1);
                rst_n = 1'b0;
                model_reset();
                #1;
                chk("mid_rst_dec", 32'(bus.ir_decode), 32'h7FFF);
                chk("mid_rst_mem", 32'(bus.ir_mem), 32'h7FFF);
                chk("mid_rst_cnt", 32'(bus.stall_cnt), 32'd0);
                step(1, rnd_instr(), 0, 1, 0, 1);
                rst_n = 1'b1;
            end
        end

        step(0, 32'h0, 0, 0, 1, 1);
        for (int i = 0; i < 65536; i++) step(0, 32'h0, 0, 1, 0, 0);
        chk("sat_cnt", 32'(bus.stall_cnt), 32'hFFFF);
        step(0, 32'h0, 0, 1, 0, 1);
        chk("sat_hold", 32'(bus.stall_cnt), 32'hFFFF);
        step(0, 32'h0, 0, 1, 1, 1);
        chk("clr_stall", 32'(bus.stall_cnt), 32'd0);
        step(0, 32'h0, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
